// File: rtl/mem_copy_engine.sv
// Byte-wise memory copy engine: latches src/dst/len on start, then alternates READ/WRITE per word.
// Optional fill mode (define MEM_COPY_FILL_EN) writes a latched fill value without reading.
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
`ifdef MEM_COPY_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_val,
`endif
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] r_remaining;
    logic [DATA_W-1:0] r_data;
    logic              r_fill;

    logic              w_fill_req;
    logic [DATA_W-1:0] w_fill_val;
    logic [1:0]        w_loop_state;

`ifdef MEM_COPY_FILL_EN
    assign w_fill_req = fill;
    assign w_fill_val = fill_val;
`else
    assign w_fill_req = 1'b0;
    assign w_fill_val = '0;
`endif

    // Fill transfers loop on WRITE; copies return to READ for the next word.
    assign w_loop_state = r_fill ? WRITE : READ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_fill      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src_ptr   <= src_addr;
                        r_dst_ptr   <= dst_addr;
                        r_remaining <= len;
                        r_fill      <= w_fill_req;
                        if (w_fill_req) begin
                            r_data <= w_fill_val;
                        end
                        if (len == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= w_fill_req ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    r_data  <= mem_rdata;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_src_ptr   <= r_src_ptr + ADDR_W'(1);
                    r_dst_ptr   <= r_dst_ptr + ADDR_W'(1);
                    r_remaining <= r_remaining - ADDR_W'(1);
                    if (r_remaining == ADDR_W'(1)) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= w_loop_state;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr_en = 1'b0;
        case (r_state)
            READ: begin
                mem_addr = r_src_ptr;
            end
            WRITE: begin
                mem_addr  = r_dst_ptr;
                mem_wdata = r_data;
                mem_wr_en = 1'b1;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    assign busy = (r_state == READ) || (r_state == WRITE);
    assign done = (r_state == DONE);

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width (256-word space).
REQ-002 SHALL have parameter DATA_W, default 8, memory word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-006 SHALL have port src_addr  input  ADDR_W  first source address.
REQ-007 SHALL have port dst_addr  input  ADDR_W  first destination address.
REQ-008 SHALL have port len  input  ADDR_W  byte count, 0..255.
REQ-009 SHALL have port mem_rdata  input  DATA_W  combinational read data from the data memory.
REQ-010 SHALL have port mem_addr  output  ADDR_W  address to the data memory.
REQ-011 SHALL have port mem_wdata  output  DATA_W  write data to the data memory.
REQ-012 SHALL have port mem_wr_en  output  1  write enable; memory writes on the clk edge where it is 1.
REQ-013 SHALL have port busy  output  1  high in READ and WRITE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement the FSM IDLE, READ, WRITE, DONE.
REQ-016 IDLE SHALL move to READ when start=1 and len!=0, and to DONE when start=1 and len=0; it SHALL stay in IDLE otherwise.
REQ-017 On leaving IDLE, src_addr, dst_addr and len SHALL be latched; later input changes SHALL have no effect.
REQ-018 READ SHALL drive mem_addr=src_ptr and mem_wr_en=0, and SHALL capture mem_rdata into a data register at the clock edge, then go to WRITE.
REQ-019 WRITE SHALL drive mem_addr=dst_ptr, mem_wdata=data register and mem_wr_en=1.
REQ-020 On leaving WRITE: src_ptr and dst_ptr SHALL increment modulo 256, and remaining SHALL decrement.
REQ-021 On leaving WRITE, the FSM SHALL go to READ if remaining!=0 after the decrement, else to DONE.
REQ-022 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-023 Latency SHALL be as follows, counting from the start edge: len=N>0 gives done in cycle 2N+1; len=0 gives done in cycle 1.
REQ-024 Address increments past 255 SHALL wrap to 0 with no error flag.
REQ-025 Overlapping regions SHALL be copied strictly in ascending order with no overlap correction (dst=src+1 replicates the first byte).
REQ-026 start SHALL be ignored while busy or in DONE.
REQ-027 Outside READ and WRITE: mem_addr=0, mem_wdata=0, mem_wr_en=0.
REQ-028 All outputs SHALL come from registered state or decode of the FSM state only, with no combinational path from start to mem_wr_en.

Reset
REQ-029 Reset SHALL force, immediately and regardless of clk: state=IDLE, busy=0, done=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, and all pointers, counter and data register to 0.
REQ-030 Reset during WRITE SHALL suppress that write.
REQ-031 Reset SHALL abandon any transfer in progress; bytes already written SHALL remain in memory.
REQ-032 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-033 When macro MEM_COPY_FILL_EN is defined, the block SHALL add input fill (1 bit) and input fill_val (DATA_W bits).
REQ-034 With MEM_COPY_FILL_EN defined and fill=1 latched at start, the block SHALL skip READ and loop WRITE only, writing fill_val to dst_ptr each cycle; done SHALL arrive in cycle N+1, and src_addr SHALL be ignored.
REQ-035 Without MEM_COPY_FILL_EN, the fill and fill_val ports SHALL be absent, and behaviour SHALL be exactly REQ-015..REQ-028.

Verification
REQ-036 The bench SHALL cover: memory preloaded with 60..63 = 10h,E0h,F0h,CCh; src=60, dst=100, len=4 -> bytes 100..103 = 10h,E0h,F0h,CCh; done in cycle 9; busy high in cycles 1..8.
REQ-037 The bench SHALL cover: len=0 with start -> no mem_wr_en ever; done=1 in cycle 1 only.
REQ-038 The bench SHALL cover: src=254, dst=10, len=4 -> reads addresses 254,255,0,1 and writes addresses 10..13 in order.
REQ-039 The bench SHALL cover: start pulsed again in cycle 3 of a len=4 transfer -> ignored, exactly 4 writes; a new start one cycle after done is accepted.
REQ-040 The bench SHALL cover: reset asserted mid-WRITE of byte 2 (len=4) -> mem_wr_en=0 immediately; dst+0 written, dst+2 and dst+3 unchanged.
REQ-041 The bench SHALL cover, with MEM_COPY_FILL_EN defined: fill=1, fill_val=A5h, dst=200, len=3 -> bytes 200..202 = A5h; done in cycle 4.
